kbd_event_decoder: RTL and testbench

Consumes PS/2 scan-code bytes from the `ps2_keyboard` receive FIFO and turns them into key events for the display and ASCII stages. It pops the FIFO through the `ready`/`nextdata_n` handshake and strips the E0/F0 prefixes into flags. It also tracks the held key, modifier state and a key-press counter. It sits between `ps2_keyboard` and `keycode_to_ascii`/`bcd7seg` in the keyboard top.

---
 rtl/kbd_event_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_kbd_event_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_event_decoder.sv
// PS/2 scan-code byte decoder: pops the receive FIFO, strips E0/F0 prefixes, emits key events.
// Optional typematic repeat filtering is enabled by defining KBD_REPEAT_FILTER_EN.
module kbd_event_decoder (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] data,
  input  logic       ready,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_make,
  output logic       evt_repeat,
  output logic       key_down,
  output logic [7:0] key_code,
  output logic [7:0] press_cnt,
  output logic       shift,
  output logic       ctrl,
  output logic       ovf_seen
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_POP   = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [1:0] CLS_KEY  = 2'd0;
  localparam logic [1:0] CLS_EXT  = 2'd1;
  localparam logic [1:0] CLS_BRK  = 2'd2;
  localparam logic [1:0] CLS_DROP = 2'd3;

  localparam logic [2:0] MOD_NONE   = 3'd0;
  localparam logic [2:0] MOD_LSHIFT = 3'd1;
  localparam logic [2:0] MOD_RSHIFT = 3'd2;
  localparam logic [2:0] MOD_LCTRL  = 3'd3;
  localparam logic [2:0] MOD_RCTRL  = 3'd4;

  state_t     state_r;
  logic [7:0] byte_r;
  logic       ext_p_r;
  logic       brk_p_r;
  logic       ovf_q_r;
  logic       held_ext_r;
  logic       lshift_r;
  logic       rshift_r;
  logic       lctrl_r;
  logic       rctrl_r;

  logic       ovf_edge_s;
  logic       ext_cur_s;
  logic       make_s;
  logic       key_evt_s;
  logic       match_s;
  logic [1:0] cls_s;
  logic [2:0] mod_s;
  logic       lshift_nx_s;
  logic       rshift_nx_s;
  logic       lctrl_nx_s;
  logic       rctrl_nx_s;

  // Classify the captured byte and work out next modifier state; an overflow edge masks the prefixes.
  always_comb begin
    ovf_edge_s = overflow & ~ovf_q_r;
    ext_cur_s  = ext_p_r & ~ovf_edge_s;
    make_s     = ~(brk_p_r & ~ovf_edge_s);

    case (byte_r)
      8'hE0:   cls_s = CLS_EXT;
      8'hF0:   cls_s = CLS_BRK;
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1:
               cls_s = CLS_DROP;
      default: cls_s = CLS_KEY;
    endcase

    case ({ext_cur_s, byte_r})
      9'h012:  mod_s = MOD_LSHIFT;
      9'h059:  mod_s = MOD_RSHIFT;
      9'h014:  mod_s = MOD_LCTRL;
      9'h114:  mod_s = MOD_RCTRL;
      default: mod_s = MOD_NONE;
    endcase

    key_evt_s = (state_r == ST_POP) && (cls_s == CLS_KEY);
    match_s   = key_down && (held_ext_r == ext_cur_s) && (key_code == byte_r);

    lshift_nx_s = lshift_r;
    rshift_nx_s = rshift_r;
    lctrl_nx_s  = lctrl_r;
    rctrl_nx_s  = rctrl_r;
    if (key_evt_s) begin
      case (mod_s)
        MOD_LSHIFT: lshift_nx_s = make_s;
        MOD_RSHIFT: rshift_nx_s = make_s;
        MOD_LCTRL:  lctrl_nx_s  = make_s;
        MOD_RCTRL:  rctrl_nx_s  = make_s;
        default:    lshift_nx_s = lshift_r;
      endcase
    end else begin
      lshift_nx_s = lshift_r;
    end
  end

  // Fetch FSM, prefix tracking, event generation and held-key bookkeeping.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r    <= ST_FETCH;
      nextdata_n <= 1'b1;
      byte_r     <= 8'h00;
      ext_p_r    <= 1'b0;
      brk_p_r    <= 1'b0;
      ovf_q_r    <= 1'b0;
      held_ext_r <= 1'b0;
      lshift_r   <= 1'b0;
      rshift_r   <= 1'b0;
      lctrl_r    <= 1'b0;
      rctrl_r    <= 1'b0;
      evt_valid  <= 1'b0;
      evt_code   <= 8'h00;
      evt_ext    <= 1'b0;
      evt_make   <= 1'b0;
      evt_repeat <= 1'b0;
      key_down   <= 1'b0;
      key_code   <= 8'h00;
      press_cnt  <= 8'h00;
      shift      <= 1'b0;
      ctrl       <= 1'b0;
      ovf_seen   <= 1'b0;
    end else begin
      ovf_q_r   <= overflow;
      evt_valid <= 1'b0;
      lshift_r  <= lshift_nx_s;
      rshift_r  <= rshift_nx_s;
      lctrl_r   <= lctrl_nx_s;
      rctrl_r   <= rctrl_nx_s;
      shift     <= lshift_nx_s | rshift_nx_s;
      ctrl      <= lctrl_nx_s | rctrl_nx_s;

      if (ovf_edge_s) begin
        ovf_seen <= 1'b1;
        ext_p_r  <= 1'b0;
        brk_p_r  <= 1'b0;
      end

      case (state_r)
        ST_FETCH: begin
          if (ready) begin
            byte_r     <= data;
            nextdata_n <= 1'b0;
            state_r    <= ST_POP;
          end else begin
            state_r    <= ST_FETCH;
          end
        end

        ST_POP: begin
          nextdata_n <= 1'b1;
          state_r    <= ST_GAP;
          case (cls_s)
            CLS_EXT: ext_p_r <= 1'b1;
            CLS_BRK: brk_p_r <= 1'b1;
            CLS_KEY: begin
              evt_valid  <= 1'b1;
              evt_code   <= byte_r;
              evt_ext    <= ext_cur_s;
              evt_make   <= make_s;
              evt_repeat <= 1'b0;
              ext_p_r    <= 1'b0;
              brk_p_r    <= 1'b0;
              if (mod_s == MOD_NONE) begin
                if (make_s) begin
`ifdef KBD_REPEAT_FILTER_EN
                  if (match_s) begin
                    evt_repeat <= 1'b1;
                  end else begin
                    key_code   <= byte_r;
                    held_ext_r <= ext_cur_s;
                    key_down   <= 1'b1;
                    press_cnt  <= press_cnt + 8'd1;
                  end
`else
                  key_code   <= byte_r;
                  held_ext_r <= ext_cur_s;
                  key_down   <= 1'b1;
                  press_cnt  <= press_cnt + 8'd1;
`endif
                end else if (match_s) begin
                  key_down <= 1'b0;
                end
              end
            end
            default: evt_valid <= 1'b0;
          endcase
        end

        // One idle cycle lets the FIFO head and ready settle after the pop.
        ST_GAP: begin
          nextdata_n <= 1'b1;
          state_r    <= ST_FETCH;
        end

        default: begin
          nextdata_n <= 1'b1;
          state_r    <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_event_decoder.sv
// Scoreboard bench for kbd_event_decoder: a FIFO model feeds bytes, a monitor checks events and pop strobes.
module tb_kbd_event_decoder;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready = 1'b0;
  logic       overflow = 1'b0;
  logic       nextdata_n, evt_valid, evt_ext, evt_make, evt_repeat, key_down;
  logic       shift, ctrl, ovf_seen;
  logic [7:0] evt_code, key_code, press_cnt;

  kbd_event_decoder dut (
    .clk(clk), .clrn(clrn), .data(data), .ready(ready), .overflow(overflow),
    .nextdata_n(nextdata_n), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_make(evt_make), .evt_repeat(evt_repeat),
    .key_down(key_down), .key_code(key_code), .press_cnt(press_cnt),
    .shift(shift), .ctrl(ctrl), .ovf_seen(ovf_seen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       make;
    logic       rep;
    logic       kd;
    logic [7:0] kc;
    logic [7:0] cnt;
    logic       sh;
    logic       ct;
  } ev_t;

  logic [7:0] fifo[$];
  ev_t        exp_q[$];
  ev_t        exp_e;
  ev_t        got_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         low_len = 0;
  int         last_start = -1;
  int         pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic make,
                           input logic rep, input logic kd, input logic [7:0] kc,
                           input logic [7:0] cnt, input logic sh, input logic ct);
    exp_q.push_back({code, ext, make, rep, kd, kc, cnt, sh, ct});
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (fifo.size() == 0 && exp_q.size() == 0) done = 1'b1;
    end
    repeat (6) @(negedge clk);
    check({"drain_", name}, {63'd0, done}, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    overflow = 1'b0;
    fifo.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  // FIFO model: head presented away from the sampling edge, popped on a low strobe.
  always @(negedge clk) begin
    ready = (fifo.size() != 0);
    data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  always @(posedge clk) begin
    if (clrn && !nextdata_n && fifo.size() != 0) void'(fifo.pop_front());
  end

  // Monitor: compares events against the scoreboard and checks pop-strobe shape.
  always @(negedge clk) begin
    cyc++;
    if (evt_valid) begin
      got_e = {evt_code, evt_ext, evt_make, evt_repeat, key_down, key_code, press_cnt, shift, ctrl};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %0h expected none", got_e);
      end else begin
        exp_e = exp_q.pop_front();
        check($sformatf("event_%02h", exp_e.code), {34'd0, got_e}, {34'd0, exp_e});
      end
    end
    if (!nextdata_n) begin
      if (low_len == 0) begin
        pulses++;
        if (last_start >= 0) check("pop_spacing", {63'd0, (cyc - last_start) >= 3}, 64'd1);
        last_start = cyc;
      end
      low_len++;
    end else if (low_len != 0) begin
      check("pop_width", 64'(low_len), 64'd1);
      low_len = 0;
    end
  end

  initial begin
    int  p0;
    bit  seen;
    repeat (3) @(negedge clk);
    check("reset_nextdata_n", {63'd0, nextdata_n}, 64'd1);
    check("reset_outs", {29'd0, evt_valid, evt_code, evt_ext, evt_make, evt_repeat, key_down,
                         key_code, press_cnt, shift, ctrl, ovf_seen}, 64'd0);
    clrn = 1'b1;
    @(negedge clk);

    // Make then break of 1C
    expect_ev(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 8'd1, 1'b0, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C, 8'd1, 1'b0, 1'b0);
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain("make_break");

    // Extended key 75
    do_reset();
    expect_ev(8'h75, 1'b1, 1'b1, 1'b0, 1'b1, 8'h75, 8'd1, 1'b0, 1'b0);
    expect_ev(8'h75, 1'b1, 1'b0, 1'b0, 1'b0, 8'h75, 8'd1, 1'b0, 1'b0);
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain("ext");

    // Typematic repeat
    do_reset();
`ifdef KBD_REPEAT_FILTER_EN
    expect_ev(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 8'd1, 1'b0, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b1, 1'b1, 1'b1, 8'h1C, 8'd1, 1'b0, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b1, 1'b1, 1'b1, 8'h1C, 8'd1, 1'b0, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C, 8'd1, 1'b0, 1'b0);
`else
    expect_ev(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 8'd1, 1'b0, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 8'd2, 1'b0, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 8'd3, 1'b0, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C, 8'd3, 1'b0, 1'b0);
`endif
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain("repeat");

    // Modifiers, discarded bytes between a prefix and its key
    do_reset();
    expect_ev(8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 8'd1, 1'b1, 1'b0);
    expect_ev(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 8'd1, 1'b0, 1'b0);
    expect_ev(8'h14, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C, 8'd1, 1'b0, 1'b1);
    expect_ev(8'h59, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 8'd1, 1'b1, 1'b1);
    expect_ev(8'h14, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1C, 8'd1, 1'b1, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C, 8'd1, 1'b1, 1'b0);
    push(8'h12); push(8'h1C); push(8'hF0); push(8'h12);
    push(8'hE0); push(8'h14); push(8'h59);
    push(8'hE0); push(8'hF0); push(8'h14);
    push(8'hF0); push(8'hAA); push(8'hFA); push(8'h00); push(8'h1C);
    drain("modifiers");

    // Four bytes queued with ready held high
    do_reset();
    p0 = pulses;
    expect_ev(8'h21, 1'b0, 1'b1, 1'b0, 1'b1, 8'h21, 8'd1, 1'b0, 1'b0);
    expect_ev(8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 8'd2, 1'b0, 1'b0);
    expect_ev(8'h23, 1'b0, 1'b1, 1'b0, 1'b1, 8'h23, 8'd3, 1'b0, 1'b0);
    expect_ev(8'h24, 1'b0, 1'b1, 1'b0, 1'b1, 8'h24, 8'd4, 1'b0, 1'b0);
    push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    drain("burst");
    check("burst_pops", 64'(pulses - p0), 64'd4);

    // Overflow edge clears a pending break prefix
    do_reset();
    push(8'hF0);
    drain("ovf_prefix");
    overflow = 1'b1;
    repeat (2) @(negedge clk);
    expect_ev(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 8'd1, 1'b0, 1'b0);
    push(8'h1C);
    drain("ovf_key");
    check("ovf_seen", {63'd0, ovf_seen}, 64'd1);

    // Reset during the pop cycle
    push(8'h2A);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!nextdata_n) seen = 1'b1;
    end
    check("midpop_reached", {63'd0, seen}, 64'd1);
    #1 clrn = 1'b0;
    fifo.delete();
    overflow = 1'b0;
    #1;
    check("midpop_nextdata_n", {63'd0, nextdata_n}, 64'd1);
    check("midpop_outs", {29'd0, evt_valid, evt_code, evt_ext, evt_make, evt_repeat, key_down,
                          key_code, press_cnt, shift, ctrl, ovf_seen}, 64'd0);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (5) @(negedge clk);
    check("leftover_expected", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
